// File: rtl/pb_io_router.sv
// -----------------------------------------------------------------------------
// pb_io_router
// PicoBlaze I/O bus router. Decodes port_id into registered read data, one-cycle
// read-acknowledge pulses, one-cycle write strobes and latched output registers,
// and hosts an edge-triggered interrupt controller mapped at IRQ_BASE/IRQ_BASE+1.
//
// Ports:
//   CLK           system clock
//   reset         asynchronous, active-low reset
//   port_id       PicoBlaze port address
//   read_strobe   PicoBlaze read strobe
//   write_strobe  PicoBlaze write strobe
//   out_port      PicoBlaze write data
//   in_port       registered read data back to PicoBlaze (1-cycle latency)
//   interrupt     registered interrupt request to PicoBlaze
//   in_data       flattened input-port data, port i at [8i+7:8i]
//   rd_ack        one-cycle read acknowledge per input port
//   wr_stb        one-cycle write strobe per output port
//   out_data      flattened latched output registers, port j at [8j+7:8j]
//   irq_src       interrupt request levels, synchronous to CLK
//
// Address map: reads of IRQ_BASE return irq_pend, reads of IRQ_BASE+1 return
// irq_en. Writes to IRQ_BASE load irq_en, writes to IRQ_BASE+1 clear irq_pend
// bits (write-one-to-clear). Both IRQ addresses take priority over any data
// port that happens to overlap them.
// -----------------------------------------------------------------------------
module pb_io_router #(
    parameter int                NUM_IN   = 8,
    parameter int                NUM_OUT  = 8,
    parameter int                NUM_IRQ  = 4,
    parameter logic [7:0]        IN_BASE  = 8'h00,
    parameter logic [7:0]        OUT_BASE = 8'h00,
    parameter logic [7:0]        IRQ_BASE = 8'hF0,
    parameter logic [NUM_IN-1:0] ACK_MASK = {NUM_IN{1'b1}}
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic [7:0]             port_id,
    input  logic                   read_strobe,
    input  logic                   write_strobe,
    input  logic [7:0]             out_port,
    output logic [7:0]             in_port,
    output logic                   interrupt,
    input  logic [8*NUM_IN-1:0]    in_data,
    output logic [NUM_IN-1:0]      rd_ack,
    output logic [NUM_OUT-1:0]     wr_stb,
    output logic [8*NUM_OUT-1:0]   out_data,
    input  logic [NUM_IRQ-1:0]     irq_src
);

    localparam logic [7:0] IRQ_ADDR0 = IRQ_BASE;
    localparam logic [7:0] IRQ_ADDR1 = IRQ_BASE + 8'd1;

    // Registered state
    logic [7:0]           in_port_r;
    logic [NUM_IN-1:0]    rd_ack_r;
    logic [NUM_OUT-1:0]   wr_stb_r;
    logic [8*NUM_OUT-1:0] out_data_r;
    logic [NUM_IRQ-1:0]   irq_en_r;
    logic [NUM_IRQ-1:0]   irq_pend_r;
    logic [NUM_IRQ-1:0]   irq_src_d_r;
    logic                 interrupt_r;

    // Decode results
    logic                 hit_irq0_s;
    logic                 hit_irq1_s;
    logic                 hit_irq_s;
    logic [NUM_IN-1:0]    in_hit_s;
    logic [NUM_OUT-1:0]   out_hit_s;
    logic [7:0]           rd_data_s;
    logic [7:0]           pend_ext_s;
    logic [7:0]           en_ext_s;
    logic [NUM_IN-1:0]    rd_ack_s;
    logic                 en_wr_s;
    logic [NUM_IRQ-1:0]   clr_s;
    logic [NUM_IRQ-1:0]   rise_s;
    logic [NUM_IRQ-1:0]   pend_nxt_s;

    // Address decode, read-data mux and interrupt next-state logic
    always_comb begin
        hit_irq0_s = (port_id == IRQ_ADDR0);
        hit_irq1_s = (port_id == IRQ_ADDR1);
        hit_irq_s  = hit_irq0_s | hit_irq1_s;

        // Data-port addresses are distinct, so at most one hit bit is set and
        // an OR-reduction of masked bytes acts as the read mux.
        in_hit_s  = '0;
        rd_data_s = 8'h00;
        for (int i = 0; i < NUM_IN; i++) begin
            in_hit_s[i] = (port_id == 8'(IN_BASE + i)) & ~hit_irq_s;
            rd_data_s   = rd_data_s | (in_data[8*i +: 8] & {8{in_hit_s[i]}});
        end
        rd_ack_s = in_hit_s & ACK_MASK & {NUM_IN{read_strobe}};

        out_hit_s = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            out_hit_s[j] = write_strobe & (port_id == 8'(OUT_BASE + j)) & ~hit_irq_s;
        end

        // Upper IRQ read bits are zero-extended.
        pend_ext_s                = 8'h00;
        pend_ext_s[NUM_IRQ-1:0]   = irq_pend_r;
        en_ext_s                  = 8'h00;
        en_ext_s[NUM_IRQ-1:0]     = irq_en_r;
        if (hit_irq0_s) begin
            rd_data_s = pend_ext_s;
        end else if (hit_irq1_s) begin
            rd_data_s = en_ext_s;
        end else begin
            rd_data_s = rd_data_s;
        end

        // Set has priority over clear on the same bit.
        en_wr_s    = write_strobe & hit_irq0_s;
        clr_s      = out_port[NUM_IRQ-1:0] & {NUM_IRQ{write_strobe & hit_irq1_s}};
        rise_s     = irq_src & ~irq_src_d_r;
        pend_nxt_s = (irq_pend_r & ~clr_s) | rise_s;
    end

    // All outputs and interrupt-controller state registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            in_port_r   <= 8'h00;
            rd_ack_r    <= '0;
            wr_stb_r    <= '0;
            out_data_r  <= '0;
            irq_en_r    <= '0;
            irq_pend_r  <= '0;
            irq_src_d_r <= '0;
            interrupt_r <= 1'b0;
        end else begin
            in_port_r   <= rd_data_s;
            rd_ack_r    <= rd_ack_s;
            wr_stb_r    <= out_hit_s;
            for (int j = 0; j < NUM_OUT; j++) begin
                if (out_hit_s[j]) begin
                    out_data_r[8*j +: 8] <= out_port;
                end
            end
            if (en_wr_s) begin
                irq_en_r <= out_port[NUM_IRQ-1:0];
            end
            irq_pend_r  <= pend_nxt_s;
            irq_src_d_r <= irq_src;
            // Uses the current pending value, so interrupt trails irq_pend by one cycle.
            interrupt_r <= |(irq_pend_r & irq_en_r);
        end
    end

    assign in_port   = in_port_r;
    assign rd_ack    = rd_ack_r;
    assign wr_stb    = wr_stb_r;
    assign out_data  = out_data_r;
    assign interrupt = interrupt_r;

endmodule

// File: tb/tb_pb_io_router.sv
module tb_pb_io_router;

    localparam int NIN  = 8;
    localparam int NOUT = 8;
    localparam int NIRQ = 4;
    localparam int IRQ0 = 240;
    localparam int IRQ1 = 241;

    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  port_id;
    logic        read_strobe;
    logic        write_strobe;
    logic [7:0]  out_port;
    logic [63:0] in_data;
    logic [3:0]  irq_src;

    logic [7:0]  in_port;
    logic        interrupt;
    logic [7:0]  rd_ack;
    logic [7:0]  wr_stb;
    logic [63:0] out_data;

    // Second instance: 3 input ports, only port 1 acknowledges
    logic [23:0] in_data2;
    logic [7:0]  in_port2;
    logic        interrupt2;
    logic [2:0]  rd_ack2;
    logic [7:0]  wr_stb2;
    logic [63:0] out_data2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    pb_io_router dut (
        .CLK(CLK), .reset(reset), .port_id(port_id), .read_strobe(read_strobe),
        .write_strobe(write_strobe), .out_port(out_port), .in_port(in_port),
        .interrupt(interrupt), .in_data(in_data), .rd_ack(rd_ack), .wr_stb(wr_stb),
        .out_data(out_data), .irq_src(irq_src)
    );

    pb_io_router #(.NUM_IN(3), .ACK_MASK(3'b010)) dut2 (
        .CLK(CLK), .reset(reset), .port_id(port_id), .read_strobe(read_strobe),
        .write_strobe(write_strobe), .out_port(out_port), .in_port(in_port2),
        .interrupt(interrupt2), .in_data(in_data2), .rd_ack(rd_ack2), .wr_stb(wr_stb2),
        .out_data(out_data2), .irq_src(irq_src)
    );

    // ---------------- behavioural reference model (default instance) ----------
    logic [7:0] m_out [NOUT];
    logic [3:0] m_en, m_pend, m_prev;
    logic [7:0] m_in_port, m_ack, m_wr;
    logic       m_int;

    function automatic logic [63:0] m_out_flat();
        logic [63:0] f;
        for (int k = 0; k < NOUT; k++) f[8*k +: 8] = m_out[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NOUT; k++) m_out[k] = 8'h00;
        m_en = 4'h0; m_pend = 4'h0; m_prev = 4'h0;
        m_in_port = 8'h00; m_ack = 8'h00; m_wr = 8'h00; m_int = 1'b0;
    endtask

    // What one rising edge does, from the documented rules
    task automatic model_edge();
        int a;
        logic [3:0] clr;
        logic [3:0] new_pend;
        a = int'(port_id);
        m_in_port = 8'h00; m_ack = 8'h00; m_wr = 8'h00;
        if (a == IRQ0)      m_in_port = {4'h0, m_pend};
        else if (a == IRQ1) m_in_port = {4'h0, m_en};
        else if (a < NIN) begin
            m_in_port = in_data[a*8 +: 8];
            if (read_strobe) m_ack = 8'(1 << a);
        end
        if (write_strobe && a != IRQ0 && a != IRQ1 && a < NOUT) begin
            m_out[a] = out_port;
            m_wr     = 8'(1 << a);
        end
        m_int    = (m_pend & m_en) != 4'h0;
        clr      = (write_strobe && a == IRQ1) ? out_port[3:0] : 4'h0;
        new_pend = (m_pend & ~clr) | (irq_src & ~m_prev);
        if (write_strobe && a == IRQ0) m_en = out_port[3:0];
        m_prev = irq_src;
        m_pend = new_pend;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".in_port"},   64'(in_port),   64'(m_in_port));
        check({tag, ".rd_ack"},    64'(rd_ack),    64'(m_ack));
        check({tag, ".wr_stb"},    64'(wr_stb),    64'(m_wr));
        check({tag, ".out_data"},  out_data,       m_out_flat());
        check({tag, ".interrupt"}, 64'(interrupt), 64'(m_int));
    endtask

    // Drive one cycle of inputs at the falling edge, return at the next falling edge
    task automatic cycle(input logic [7:0] pid, input logic rs, input logic ws,
                         input logic [7:0] op, input logic [3:0] src);
        port_id = pid; read_strobe = rs; write_strobe = ws; out_port = op; irq_src = src;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] pid;
        logic       rs;
        logic       ws;
        logic [7:0] op;
        logic [3:0] src;
        logic [7:0] e_in;
        logic [7:0] e_ack;
        logic [7:0] e_wr;
        logic       e_int;
    } vec_t;

    localparam int NVEC = 21;
    vec_t tbl [NVEC];

    initial begin
        tbl[0]  = '{8'h02, 1'b1, 1'b0, 8'h00, 4'h0, 8'hA5, 8'h04, 8'h00, 1'b0}; // read port 2
        tbl[1]  = '{8'h02, 1'b0, 1'b0, 8'h00, 4'h0, 8'hA5, 8'h00, 8'h00, 1'b0}; // ack is 1 cycle
        tbl[2]  = '{8'h05, 1'b0, 1'b1, 8'h3C, 4'h0, 8'h33, 8'h00, 8'h20, 1'b0}; // write port 5
        tbl[3]  = '{8'h40, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0}; // unmapped read
        tbl[4]  = '{8'h40, 1'b1, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0}; // unmapped strobe
        tbl[5]  = '{8'hF0, 1'b0, 1'b1, 8'h01, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0}; // irq_en = 1
        tbl[6]  = '{8'hF1, 1'b0, 1'b0, 8'h00, 4'h1, 8'h01, 8'h00, 8'h00, 1'b0}; // src0 rises
        tbl[7]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 4'h1, 8'h01, 8'h00, 8'h00, 1'b1}; // pend, int
        tbl[8]  = '{8'hF1, 1'b0, 1'b1, 8'h01, 4'h1, 8'h01, 8'h00, 8'h00, 1'b1}; // W1C bit0
        tbl[9]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 4'h1, 8'h00, 8'h00, 8'h00, 1'b0}; // int drops
        tbl[10] = '{8'hF0, 1'b0, 1'b0, 8'h00, 4'h1, 8'h00, 8'h00, 8'h00, 1'b0}; // no retrigger
        tbl[11] = '{8'hF1, 1'b0, 1'b1, 8'h02, 4'h3, 8'h01, 8'h00, 8'h00, 1'b0}; // set vs clear
        tbl[12] = '{8'hF0, 1'b0, 1'b0, 8'h00, 4'h3, 8'h02, 8'h00, 8'h00, 1'b0}; // set won
        tbl[13] = '{8'hF0, 1'b0, 1'b0, 8'h00, 4'h3, 8'h02, 8'h00, 8'h00, 1'b0}; // disabled: no int
        tbl[14] = '{8'hF0, 1'b0, 1'b1, 8'h03, 4'h3, 8'h02, 8'h00, 8'h00, 1'b0}; // enable bit1
        tbl[15] = '{8'hF0, 1'b0, 1'b0, 8'h00, 4'h3, 8'h02, 8'h00, 8'h00, 1'b1};
        tbl[16] = '{8'hF0, 1'b0, 1'b1, 8'hF0, 4'h3, 8'h02, 8'h00, 8'h00, 1'b1}; // upper bits ignored
        tbl[17] = '{8'hF1, 1'b0, 1'b0, 8'h00, 4'h3, 8'h00, 8'h00, 8'h00, 1'b0}; // en reads 0
        tbl[18] = '{8'hF1, 1'b0, 1'b1, 8'hFF, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0}; // clear all
        tbl[19] = '{8'h07, 1'b1, 1'b0, 8'h00, 4'h0, 8'h11, 8'h80, 8'h00, 1'b0}; // last port
        tbl[20] = '{8'h08, 1'b1, 1'b1, 8'h5A, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0}; // just past range
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] src;
        int sel;
        logic [7:0] pid;

        reset = 1'b0; port_id = 8'h00; read_strobe = 1'b0; write_strobe = 1'b0;
        out_port = 8'h00; irq_src = 4'h0;
        in_data  = 64'h11_22_33_44_55_A5_77_88;
        in_data2 = 24'hC3_B2_A1;
        model_reset();
        repeat (3) @(negedge CLK);
        check("reset.in_port",   64'(in_port),   64'h0);
        check("reset.rd_ack",    64'(rd_ack),    64'h0);
        check("reset.wr_stb",    64'(wr_stb),    64'h0);
        check("reset.out_data",  out_data,       64'h0);
        check("reset.interrupt", 64'(interrupt), 64'h0);
        reset = 1'b1;

        // Directed table
        for (int v = 0; v < NVEC; v++) begin
            cycle(tbl[v].pid, tbl[v].rs, tbl[v].ws, tbl[v].op, tbl[v].src);
            check($sformatf("vec%0d.in_port", v),   64'(in_port),   64'(tbl[v].e_in));
            check($sformatf("vec%0d.rd_ack", v),    64'(rd_ack),    64'(tbl[v].e_ack));
            check($sformatf("vec%0d.wr_stb", v),    64'(wr_stb),    64'(tbl[v].e_wr));
            check($sformatf("vec%0d.interrupt", v), 64'(interrupt), 64'(tbl[v].e_int));
            check($sformatf("vec%0d.out_data", v),  out_data,       m_out_flat());
        end
        check("out5_hold", 64'(out_data[47:40]), 64'h3C);

        // Reset while a write strobe and read ack are both high
        cycle(8'hF0, 1'b0, 1'b1, 8'h01, 4'h0);
        cycle(8'h03, 1'b1, 1'b1, 8'hAA, 4'h1);
        check("pre_rst.wr_stb", 64'(wr_stb), 64'h08);
        check("pre_rst.rd_ack", 64'(rd_ack), 64'h08);
        reset = 1'b0;
        irq_src = 4'h0; read_strobe = 1'b0; write_strobe = 1'b0; port_id = 8'h40;
        #1;
        model_reset();
        check_model("in_rst");
        repeat (2) @(negedge CLK);
        check_model("held_rst");
        reset = 1'b1;
        cycle(8'h40, 1'b0, 1'b0, 8'h00, 4'h0);
        check_model("post_rst");
        cycle(8'hF0, 1'b0, 1'b0, 8'h00, 4'h0);
        check_model("post_rst.pend");
        cycle(8'h40, 1'b0, 1'b0, 8'h00, 4'h0);
        check_model("post_rst.int");

        // Three-port instance with a partial acknowledge mask
        cycle(8'h00, 1'b1, 1'b0, 8'h00, 4'h0);
        check("n3.p0.in_port", 64'(in_port2), 64'hA1);
        check("n3.p0.rd_ack",  64'(rd_ack2),  64'h0);
        cycle(8'h01, 1'b1, 1'b0, 8'h00, 4'h0);
        check("n3.p1.in_port", 64'(in_port2), 64'hB2);
        check("n3.p1.rd_ack",  64'(rd_ack2),  64'h2);
        cycle(8'h03, 1'b1, 1'b1, 8'h66, 4'h0);
        check("n3.p3.in_port", 64'(in_port2), 64'h00);
        check("n3.p3.rd_ack",  64'(rd_ack2),  64'h0);
        check("n3.wr_stb",     64'(wr_stb2),  64'(m_wr));
        check("n3.out_data",   out_data2,     m_out_flat());
        check("n3.interrupt",  64'(interrupt2), 64'(m_int));

        // Randomized traffic against the model
        src = 4'h0;
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 5)      pid = 8'($urandom_range(0, 9));
            else if (sel == 6) pid = 8'hF0;
            else if (sel == 7) pid = 8'hF1;
            else if (sel == 8) pid = 8'($urandom_range(0, 255));
            else               pid = 8'h40;
            if ($urandom_range(0, 3) == 0) src = src ^ 4'($urandom);
            in_data = {$urandom, $urandom};
            cycle(pid, 1'($urandom), 1'($urandom), 8'($urandom), src);
            check_model($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
